// File: rtl/result_writer.sv
// result_writer: writeback stage following the ALU.
// Takes a computed result plus a destination descriptor and either performs
// one handshaked memory write at (base [-1 on push]) + offset, or a direct
// register write. Pulses done on completion so the step sequencer can advance.
//
// Ports:
//   clock, reset       core clock, synchronous active-high reset
//   start              request strobe, sampled only in IDLE
//   value              result to store
//   base               current value of the destination base register
//   offset             unsigned word offset added to the (possibly decremented) base
//   destination_mem    1 = memory write, 0 = register write of value
//   push               with destination_mem: pre-decrement base and update register
//   mem_ready          memory accepts the write when write_enable & mem_ready
//   write_address      memory address (held stable through WRITE)
//   write_data         memory data (held stable through WRITE)
//   write_enable       memory write request
//   register_out       value for the destination register
//   register_write     one-cycle register write strobe
//   busy               high in any state other than IDLE
//   done               one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start; captures the request descriptor
// ADDR  | computes address/data/new base from the captured descriptor
// WRITE | write_enable high until mem_ready is seen
// DONE  | completion pulse, optional register write
module result_writer #(
  parameter int WIDTH        = 16,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  input  logic [WIDTH-1:0]        base,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    destination_mem,
  input  logic                    push,
  input  logic                    mem_ready,
  output logic [WIDTH-1:0]        write_address,
  output logic [WIDTH-1:0]        write_data,
  output logic                    write_enable,
  output logic [WIDTH-1:0]        register_out,
  output logic                    register_write,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]        value_c;
  logic [WIDTH-1:0]        base_c;
  logic [OFFSET_WIDTH-1:0] offset_c;
  logic                    dest_mem_c;
  logic                    push_c;

  logic [WIDTH-1:0] address_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] new_base_r;

  logic [WIDTH-1:0] new_base;
  logic [WIDTH-1:0] offset_ext;

  // Subtraction wraps naturally: 0x0000 - 1 = all ones.
  assign new_base   = base_c - {{(WIDTH-1){1'b0}}, push_c};
  assign offset_ext = {{(WIDTH-OFFSET_WIDTH){1'b0}}, offset_c};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = destination_mem ? ADDR : DONE;
      ADDR:    state_next = WRITE;
      WRITE:   if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      value_c    <= '0;
      base_c     <= '0;
      offset_c   <= '0;
      dest_mem_c <= 1'b0;
      push_c     <= 1'b0;
      address_r  <= '0;
      data_r     <= '0;
      new_base_r <= '0;
    end else begin
      state <= state_next;
      // Capture only in IDLE so starts during an active request are ignored.
      if (state == IDLE && start) begin
        value_c    <= value;
        base_c     <= base;
        offset_c   <= offset;
        dest_mem_c <= destination_mem;
        push_c     <= push;
      end
      if (state == ADDR) begin
        address_r  <= new_base + offset_ext;
        data_r     <= value_c;
        new_base_r <= new_base;
      end
    end
  end

  assign write_address  = address_r;
  assign write_data     = data_r;
  assign write_enable   = (state == WRITE);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  // push only matters on the memory path; a register-only request always writes.
  assign register_write = (state == DONE) && (!dest_mem_c || push_c);
  assign register_out   = (state == DONE && !dest_mem_c) ? value_c : new_base_r;

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] value;
  logic [15:0] base;
  logic [3:0]  offset;
  logic        destination_mem;
  logic        push;
  logic        mem_ready;
  logic [15:0] write_address;
  logic [15:0] write_data;
  logic        write_enable;
  logic [15:0] register_out;
  logic        register_write;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  result_writer #(.WIDTH(16), .OFFSET_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value), .base(base),
    .offset(offset), .destination_mem(destination_mem), .push(push),
    .mem_ready(mem_ready), .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .register_out(register_out),
    .register_write(register_write), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Transaction-level model: an accepted request is a descriptor plus the
  // number of cycles it has been in flight; outputs follow from that.
  bit          m_active = 0;
  bit          m_mem;
  bit          m_push;
  bit          m_wrote;
  int          m_age;
  logic [15:0] m_value;
  logic [15:0] m_addr;
  logic [15:0] m_newbase;

  // Inputs change only just after a rising edge, so values seen at the falling
  // edge are exactly the ones the next rising edge samples.
  always @(negedge clock) begin
    bit exp_done, exp_we, exp_rw;
    exp_done = m_active && (m_mem ? m_wrote : 1'b1);
    exp_we   = m_active && m_mem && m_age >= 1 && !m_wrote;
    exp_rw   = exp_done && (!m_mem || m_push);
    if (!reset || m_active) begin
      check("busy", busy, m_active);
      check("done", done, exp_done);
      check("write_enable", write_enable, exp_we);
      check("register_write", register_write, exp_rw);
      if (exp_we) begin
        check("write_address", write_address, m_addr);
        check("write_data", write_data, m_value);
      end
      if (exp_rw)
        check("register_out", register_out, m_mem ? m_newbase : m_value);
    end
    if (reset) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active  = 1;
        m_mem     = destination_mem;
        m_push    = push;
        m_value   = value;
        m_newbase = base - (push ? 16'd1 : 16'd0);
        m_addr    = m_newbase + {12'd0, offset};
        m_wrote   = 0;
        m_age     = 0;
      end
    end else begin
      if (exp_done) m_active = 0;
      else if (exp_we && mem_ready) m_wrote = 1;
      m_age++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [15:0] v, input logic [15:0] b, input logic [3:0] o,
                         input logic dm, input logic p);
    start = 1'b1; value = v; base = b; offset = o; destination_mem = dm; push = p;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; value = '0; base = '0; offset = '0;
    destination_mem = 1'b0; push = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_write_address", write_address, 16'h0000);
    check("reset_register_out", register_out, 16'h0000);
    tick();

    // 1: register-only write
    request(16'h1234, 16'h0777, 4'h5, 1'b0, 1'b0);
    tick(); start = 1'b0;
    check("t1_done", done, 1'b1);
    check("t1_register_write", register_write, 1'b1);
    check("t1_register_out", register_out, 16'h1234);
    tick();
    check("t1_busy_after", busy, 1'b0);

    // 2: memory write, ready high
    request(16'hBEEF, 16'h0100, 4'h3, 1'b1, 1'b0); mem_ready = 1'b1;
    tick(); start = 1'b0;
    check("t2_addr_no_we", write_enable, 1'b0);
    tick();
    check("t2_we", write_enable, 1'b1);
    check("t2_address", write_address, 16'h0103);
    check("t2_data", write_data, 16'hBEEF);
    tick();
    check("t2_done", done, 1'b1);
    check("t2_register_write", register_write, 1'b0);
    tick();

    // 3: push from 0x0000, ready low for 3 write cycles
    request(16'h00AA, 16'h0000, 4'h0, 1'b1, 1'b1); mem_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t3_we_wait", write_enable, 1'b1);
      check("t3_address", write_address, 16'hFFFF);
      check("t3_data", write_data, 16'h00AA);
      tick();
    end
    mem_ready = 1'b1;
    check("t3_we_last", write_enable, 1'b1);
    tick();
    check("t3_done", done, 1'b1);
    check("t3_register_write", register_write, 1'b1);
    check("t3_register_out", register_out, 16'hFFFF);
    tick();

    // 4: address wrap
    request(16'h0042, 16'hFFFE, 4'hF, 1'b1, 1'b0);
    tick(); start = 1'b0;
    tick();
    check("t4_address", write_address, 16'h000D);
    tick(); tick();

    // 5: reset during WRITE with ready low
    request(16'h7777, 16'h0010, 4'h1, 1'b1, 1'b0); mem_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    check("t5_we_before", write_enable, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_we_after", write_enable, 1'b0);
    check("t5_busy_after", busy, 1'b0);
    check("t5_done_after", done, 1'b0);
    mem_ready = 1'b1;
    request(16'h5A5A, 16'h0000, 4'h0, 1'b0, 1'b0);
    tick(); start = 1'b0;
    check("t5_recover_done", done, 1'b1);
    check("t5_recover_out", register_out, 16'h5A5A);
    tick();

    // 6: starts while busy and in the done cycle are ignored
    request(16'h1111, 16'h0200, 4'h1, 1'b1, 1'b0);
    tick();
    request(16'h2222, 16'h0300, 4'h2, 1'b1, 1'b1);
    tick();
    check("t6_address", write_address, 16'h0201);
    check("t6_data", write_data, 16'h1111);
    request(16'h3333, 16'h0400, 4'h3, 1'b0, 1'b0);
    tick();
    check("t6_done_first", done, 1'b1);
    check("t6_no_rw_first", register_write, 1'b0);
    request(16'h4444, 16'h0500, 4'h4, 1'b0, 1'b0);
    tick();
    check("t6_idle_between", busy, 1'b0);
    request(16'h5555, 16'h0600, 4'h5, 1'b0, 1'b0);
    tick(); start = 1'b0;
    check("t6_done_second", done, 1'b1);
    check("t6_register_out", register_out, 16'h5555);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Writeback-direction counterpart to the immediate/operand fetch path in the uCISC reference core.
- Takes a computed result and a destination descriptor (base register value, 4-bit offset, memory/register flag, push flag).
- Either drives one memory write cycle with ready handshake, or a direct register write.
- Sits after the ALU. Reports completion so the step sequencer can advance to the next instruction.

Parameters:
- WIDTH, 16, data/address width.
- OFFSET_WIDTH, 4, width of the destination offset field.

Ports:
- clock  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- value  input  WIDTH  result to store.
- base  input  WIDTH  current value of the destination base register.
- offset  input  OFFSET_WIDTH  unsigned word offset added to the (possibly decremented) base.
- destination_mem  input  1  1 = write to memory; 0 = write value to the register itself.
- push  input  1  1 with destination_mem = pre-decrement base, write at new base + offset, update register.
- mem_ready  input  1  memory accepts the write in any cycle where write_enable and mem_ready are both 1.
- write_address  output  WIDTH  memory address.
- write_data  output  WIDTH  memory data.
- write_enable  output  1  memory write request.
- register_out  output  WIDTH  value for the destination register.
- register_write  output  1  one-cycle register write strobe.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, ADDR, WRITE, DONE. State is encoded in registers; all outputs are registered or decoded from state plus captured registers.
- Reset: state = IDLE; all captured registers = 0; write_enable, register_write, busy, done = 0; write_address, write_data, register_out = 0.
- IDLE:
  - If start = 0, remain in IDLE.
  - If start = 1, capture value, base, offset, destination_mem, push.
  - Next state is ADDR if destination_mem = 1, otherwise DONE.
- ADDR (1 cycle):
  - new_base = push ? base_c - 1 : base_c, computed mod 2^WIDTH (0x0000 - 1 = 0xFFFF).
  - write_address <= new_base + zero-extended offset_c, mod 2^WIDTH (wraps past 0xFFFF).
  - write_data <= value_c.
  - register_out <= new_base.
  - Next state: WRITE.
- WRITE:
  - write_enable = 1; address and data held stable.
  - If mem_ready = 0, stay in WRITE indefinitely; there is no timeout.
  - If mem_ready = 1, the write completes this cycle. Next state: DONE. write_enable is 0 from the next cycle.
- DONE (1 cycle):
  - done = 1.
  - register_write = 1 if (destination_mem = 0) or (push = 1); otherwise 0.
  - If destination_mem = 0: register_out = value_c, and write_enable is never asserted for this request.
  - Next state: IDLE.
- start while busy is ignored: no queueing, and captured values are unaffected.
- Latency, start to done:
  - Register-only path: done in the 2nd cycle after start.
  - Memory path with mem_ready held high: done in the 4th cycle (IDLE→ADDR→WRITE→DONE).
  - Each cycle mem_ready is held low adds one cycle.
- Reset mid-operation (any state, including WRITE with mem_ready low):
  - Returns to IDLE next edge.
  - write_enable drops in that same next cycle.
  - No done or register_write pulse is produced.
- push with destination_mem = 0: push is ignored; behaves as a register-only write.
- start in the same cycle done is high: the FSM is in DONE, not IDLE, so start is ignored. The earliest accepted back-to-back start is in the cycle after done.

Test Plan:
1. Reset, then start with destination_mem=0, value=0x1234 → no write_enable; register_write=1, register_out=0x1234, done=1 exactly 2 cycles after start; busy=0 afterwards.
2. start with destination_mem=1, push=0, base=0x0100, offset=3, value=0xBEEF, mem_ready=1 → one write_enable cycle with write_address=0x0103, write_data=0xBEEF; done at cycle 4; register_write=0.
3. Push with base=0x0000, offset=0, value=0x00AA, mem_ready low for 3 cycles → write_address=0xFFFF and write_enable held 4 cycles, stable data throughout; in DONE, register_write=1 with register_out=0xFFFF.
4. Offset wrap: base=0xFFFE, offset=0xF, push=0 → write_address=0x000D.
5. Assert reset during WRITE with mem_ready=0 → next cycle write_enable=0, busy=0, no done; a new request then completes normally.
6. Pulse start every cycle during an active request, then again in the cycle done is high → only the first request executes; the request is accepted in the cycle after done, and its captured value matches the inputs at that cycle.
